montgomery_const_gen: RTL and testbench

- Parametrised Montgomery precompute engine. For an odd modulus N of DATA_LENGTH bits, it computes R mod N and R^2 mod N, where R = 2^DATA_LENGTH.
- It uses iterative modular doubling only: no wide multiplier and no 2*DATA_LENGTH-bit divider.
- It feeds the Montgomery multiplier / modexp datapath of the RSA decryption path.
- Successor to the fixed 1024-bit r/t constant block. It adds width generalisation, reset, busy/err handshake and an optional R^3 term.

---
 rtl/montgomery_const_gen.sv | 132 +++++++++++++
 tb/tb_montgomery_const_gen.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/montgomery_const_gen.sv
// Montgomery precompute: R mod N and R^2 mod N (R = 2^DATA_LENGTH) by repeated modular doubling.
// Latency: done in cycle 2W+1 after the accepted start (3W+1 with CONST_R3_EN), cycle 1 on a rejected modulus.
// No backpressure: start is sampled only in IDLE; optional R^3 term enabled by macro CONST_R3_EN.
module montgomery_const_gen #(
  parameter int DATA_LENGTH = 1024,
  parameter int CNT_WIDTH   = $clog2(DATA_LENGTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DATA_LENGTH-1:0] M_r,
  output logic [DATA_LENGTH-1:0] R_r,
  output logic [DATA_LENGTH-1:0] R_t,
`ifdef CONST_R3_EN
  output logic [DATA_LENGTH-1:0] R_c,
`endif
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

`ifdef CONST_R3_EN
  typedef enum logic [2:0] {IDLE, RUN_R, RUN_T, RUN_C, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RUN_R, RUN_T, DONE} state_t;
`endif

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DATA_LENGTH - 1);

  state_t                 state, state_n;
  logic [DATA_LENGTH-1:0] m_reg;
  logic [DATA_LENGTH-1:0] acc;
  logic [DATA_LENGTH-1:0] acc_next;
  logic [DATA_LENGTH:0]   dbl;
  logic [CNT_WIDTH-1:0]   count;
  logic                   last_step;
  logic                   reject;

  // Zero or even moduli have no Montgomery inverse and are refused up front.
  assign reject    = (M_r == '0) || !M_r[0];
  assign last_step = (count == LAST);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  // One modular doubling: acc < N keeps 2*acc < 2N, so a single subtract suffices.
  always_comb begin
    dbl      = {acc, 1'b0};
    acc_next = dbl[DATA_LENGTH-1:0];
    if (dbl >= {1'b0, m_reg}) begin
      acc_next = DATA_LENGTH'(dbl - {1'b0, m_reg});
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state: three (or two) W-step passes, then a single DONE cycle.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (start) state_n = reject ? DONE : RUN_R;
      RUN_R: if (last_step) state_n = RUN_T;
`ifdef CONST_R3_EN
      RUN_T: if (last_step) state_n = RUN_C;
      RUN_C: if (last_step) state_n = DONE;
`else
      RUN_T: if (last_step) state_n = DONE;
`endif
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: capture modulus on start, step acc each RUN cycle, snapshot at pass ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_reg <= '0;
      acc   <= '0;
      count <= '0;
      R_r   <= '0;
      R_t   <= '0;
`ifdef CONST_R3_EN
      R_c   <= '0;
`endif
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= M_r;
            count <= '0;
            err   <= reject;
            if (reject) begin
              acc <= '0;
              R_r <= '0;
              R_t <= '0;
`ifdef CONST_R3_EN
              R_c <= '0;
`endif
            end else begin
              // N == 1 means every residue is 0, including the seed 2^0.
              acc <= (M_r == DATA_LENGTH'(1)) ? '0 : DATA_LENGTH'(1);
            end
          end
        end
        RUN_R, RUN_T
`ifdef CONST_R3_EN
        , RUN_C
`endif
        : begin
          acc   <= acc_next;
          count <= last_step ? '0 : count + 1'b1;
          if (last_step) begin
            if (state == RUN_R) R_r <= acc_next;
            if (state == RUN_T) R_t <= acc_next;
`ifdef CONST_R3_EN
            if (state == RUN_C) R_c <= acc_next;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_montgomery_const_gen.sv
// Directed bench for montgomery_const_gen at W=8 and W=1024 with hand-computed residues.
// Checks done latency, busy window, err, start-while-busy and mid-run reset.
// Honours CONST_R3_EN for the extra R_c checks and latency.
module tb_montgomery_const_gen;

`ifdef CONST_R3_EN
  localparam int LAT8  = 25;
  localparam int LAT1K = 3073;
`else
  localparam int LAT8  = 17;
  localparam int LAT1K = 2049;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start8 = 1'b0;
  logic [7:0]  m8 = '0;
  logic [7:0]  r8, t8;
  logic        busy8, done8, err8;
`ifdef CONST_R3_EN
  logic [7:0]  c8;
`endif

  logic           start1k = 1'b0;
  logic [1023:0]  m1k = '0;
  logic [1023:0]  r1k, t1k;
  logic           busy1k, done1k, err1k;
`ifdef CONST_R3_EN
  logic [1023:0]  c1k;
`endif

  montgomery_const_gen #(.DATA_LENGTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .M_r(m8),
    .R_r(r8), .R_t(t8),
`ifdef CONST_R3_EN
    .R_c(c8),
`endif
    .busy(busy8), .done(done8), .err(err8)
  );

  montgomery_const_gen #(.DATA_LENGTH(1024)) dut1k (
    .clk(clk), .rst_n(rst_n), .start(start1k), .M_r(m1k),
    .R_r(r1k), .R_t(t1k),
`ifdef CONST_R3_EN
    .R_c(c1k),
`endif
    .busy(busy1k), .done(done1k), .err(err1k)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [1023:0] got, input logic [1023:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // Pulse start for one edge, scramble M_r afterwards, return the cycle done rose (-1 on timeout).
  task automatic run8(input logic [7:0] n, output int dcyc);
    dcyc = -1;
    @(negedge clk);
    m8 = n;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    m8 = ~n;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done8) begin
        dcyc = c;
        break;
      end
    end
  endtask

  initial begin
    int dc;
    logic [1023:0] n_big, r_big;

    repeat (2) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_err",  err8,  0);
    chk("rst_rr",   r8,    0);
    chk("rst_rt",   t8,    0);
    rst_n = 1'b1;

    // N=13: 2^8=256=19*13+9, 9^2=81=6*13+3, 9*3=27=2*13+1.
    run8(8'd13, dc);
    chk("n13_lat", dc, LAT8);
    chk("n13_rr", r8, 9);
    chk("n13_rt", t8, 3);
    chk("n13_err", err8, 0);
`ifdef CONST_R3_EN
    chk("n13_rc", c8, 1);
`endif

    // N=251: 256-251=5, 5^2=25, 5^3=125.
    run8(8'd251, dc);
    chk("n251_rr", r8, 5);
    chk("n251_rt", t8, 25);
`ifdef CONST_R3_EN
    chk("n251_rc", c8, 125);
`endif

    run8(8'd255, dc);
    chk("n255_rr", r8, 1);
    chk("n255_rt", t8, 1);

    run8(8'd1, dc);
    chk("n1_rr", r8, 0);
    chk("n1_rt", t8, 0);
    chk("n1_err", err8, 0);

    // Even and zero moduli: rejected, done at cycle 1, busy only in DONE.
    run8(8'd12, dc);
    chk("n12_lat", dc, 1);
    chk("n12_err", err8, 1);
    chk("n12_busy", busy8, 1);
    chk("n12_rr", r8, 0);
    chk("n12_rt", t8, 0);
    @(negedge clk);
    chk("n12_busy_after", busy8, 0);

    run8(8'd0, dc);
    chk("n0_lat", dc, 1);
    chk("n0_err", err8, 1);

    // start pulsed mid-run and in DONE must be ignored.
    @(negedge clk);
    m8 = 8'd13;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    m8 = 8'd251;
    dc = -1;
    for (int c = 1; c <= LAT8 + 3; c++) begin
      @(negedge clk);
      start8 = 1'b0;
      if (c <= LAT8) chk($sformatf("ign_busy%0d", c), busy8, 1);
      else           chk($sformatf("ign_idle%0d", c), busy8, 0);
      if (done8 && dc < 0) dc = c;
      if (c == 5 || c == LAT8) start8 = 1'b1;
    end
    start8 = 1'b0;
    chk("ign_lat", dc, LAT8);
    chk("ign_rr", r8, 9);
    chk("ign_rt", t8, 3);

    // Reset at cycle 6 of a run aborts it and clears outputs.
    @(negedge clk);
    m8 = 8'd13;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", busy8, 0);
    chk("ar_done", done8, 0);
    chk("ar_rr", r8, 0);
    chk("ar_rt", t8, 0);
    chk("ar_err", err8, 0);
    dc = 0;
    repeat (3) begin
      @(negedge clk);
      if (done8) dc++;
    end
    rst_n = 1'b1;
    repeat (LAT8) begin
      @(negedge clk);
      if (done8) dc++;
    end
    chk("ar_nodone", dc, 0);
    run8(8'd251, dc);
    chk("ar_rr2", r8, 5);
    chk("ar_rt2", t8, 25);

    // W=1024, N=2^1023+1: 2^1024 = 2N-2 -> N-2 = 2^1023-1; (-2)^2 = 4; (-2)^3 = N-8.
    n_big = '0;
    n_big[1023] = 1'b1;
    n_big[0] = 1'b1;
    r_big = {1'b0, {1023{1'b1}}};
    @(negedge clk);
    m1k = n_big;
    start1k = 1'b1;
    @(posedge clk);
    #1;
    start1k = 1'b0;
    m1k = '0;
    dc = -1;
    for (int c = 1; c <= LAT1K + 10; c++) begin
      @(negedge clk);
      if (done1k) begin
        dc = c;
        break;
      end
    end
    chk("w1k_lat", dc, LAT1K);
    chk("w1k_rr", r1k, r_big);
    chk("w1k_rt", t1k, 1024'd4);
    chk("w1k_err", err1k, 0);
`ifdef CONST_R3_EN
    chk("w1k_rc", c1k, n_big - 1024'd8);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
